// File: rtl/rxcea.sv
// rtl/rxcea.sv - 5-byte request frame parser feeding txcea with cmd/cmd_flag
module rxcea #(
    parameter logic [15:0] DEV_ID      = 16'h0001,
    parameter logic [15:0] BCAST_ID    = 16'hFFFF,
    parameter int          TIMEOUT_CYC = 5000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_flag,
    output logic [7:0] cmd,
    output logic       cmd_flag,
    output logic       frame_err,
    output logic [1:0] err_type,
    output logic       busy
);

    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDH = 3'd0,
        S_IDL = 3'd1,
        S_CMD = 3'd2,
        S_CKH = 3'd3,
        S_CKL = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    sum_q, sum_d;
    logic [15:0]   id_q, id_d;
    logic [7:0]    cmd_r_q, cmd_r_d;
    logic [7:0]    chk_h_q, chk_h_d;
    logic [7:0]    cmd_q, cmd_d;
    logic          cmd_flag_q, cmd_flag_d;
    logic          frame_err_q, frame_err_d;
    logic [1:0]    err_type_q, err_type_d;

    logic timeout;
    logic id_ok;
    logic chk_ok;

    // A stalled partial frame expires only if no byte lands in the expiry cycle.
    assign timeout = (state_q != S_IDH) && !rx_flag && (cnt_q == CNT_LAST);
    assign id_ok   = (id_q == DEV_ID) || (id_q == BCAST_ID);
    assign chk_ok  = ({6'b0, sum_q} == {chk_h_q, rx_data});

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q     <= S_IDH;
            cnt_q       <= '0;
            sum_q       <= '0;
            id_q        <= '0;
            cmd_r_q     <= '0;
            chk_h_q     <= '0;
            cmd_q       <= '0;
            cmd_flag_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_type_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            id_q        <= id_d;
            cmd_r_q     <= cmd_r_d;
            chk_h_q     <= chk_h_d;
            cmd_q       <= cmd_d;
            cmd_flag_q  <= cmd_flag_d;
            frame_err_q <= frame_err_d;
            err_type_q  <= err_type_d;
        end
    end

    // Next state: one step per byte strobe, back to S_IDH on timeout; inter-byte counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rx_flag) begin
            case (state_q)
                S_IDH:   state_d = S_IDL;
                S_IDL:   state_d = S_CMD;
                S_CMD:   state_d = S_CKH;
                S_CKH:   state_d = S_CKL;
                default: state_d = S_IDH;
            endcase
        end else if (timeout) begin
            state_d = S_IDH;
        end
        if (rx_flag || (state_q == S_IDH)) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Byte capture, frame evaluation on CHK_L, and registered result pulses.
    always_comb begin
        sum_d       = sum_q;
        id_d        = id_q;
        cmd_r_d     = cmd_r_q;
        chk_h_d     = chk_h_q;
        cmd_d       = cmd_q;
        cmd_flag_d  = 1'b0;
        frame_err_d = 1'b0;
        err_type_d  = err_type_q;
        if (rx_flag) begin
            case (state_q)
                S_IDH: begin
                    sum_d      = {2'b00, rx_data};
                    id_d[15:8] = rx_data;
                end
                S_IDL: begin
                    sum_d     = sum_q + {2'b00, rx_data};
                    id_d[7:0] = rx_data;
                end
                S_CMD: begin
                    sum_d   = sum_q + {2'b00, rx_data};
                    cmd_r_d = rx_data;
                end
                S_CKH: begin
                    chk_h_d = rx_data;
                end
                default: begin
                    // Foreign IDs are dropped silently, checksum not examined.
                    if (id_ok) begin
                        if (chk_ok) begin
                            cmd_d      = cmd_r_q;
                            cmd_flag_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            err_type_d  = 2'b01;
                        end
                    end
                end
            endcase
        end else if (timeout) begin
            frame_err_d = 1'b1;
            err_type_d  = 2'b10;
        end
    end

    assign cmd       = cmd_q;
    assign cmd_flag  = cmd_flag_q;
    assign frame_err = frame_err_q;
    assign err_type  = err_type_q;
    assign busy      = (state_q != S_IDH);

endmodule

// File: tb/tb_rxcea.sv
// tb/tb_rxcea.sv - directed self-checking bench for rxcea
module tb_rxcea;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_flag = 1'b0;
    logic [7:0] cmd;
    logic       cmd_flag;
    logic       frame_err;
    logic [1:0] err_type;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int flag_cnt = 0;
    int err_cnt  = 0;
    int f0, e0, hit;

    rxcea #(.DEV_ID(16'h0001), .BCAST_ID(16'hFFFF), .TIMEOUT_CYC(20)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .rx_data  (rx_data),
        .rx_flag  (rx_flag),
        .cmd      (cmd),
        .cmd_flag (cmd_flag),
        .frame_err(frame_err),
        .err_type (err_type),
        .busy     (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (cmd_flag)  flag_cnt <= flag_cnt + 1;
        if (frame_err) err_cnt  <= err_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe one byte; returns 1 time unit after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_flag = 1'b1;
        @(posedge sys_clk); #1;
        rx_flag = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk); #1;
        end
    endtask

    // Five bytes spaced 5 cycles; returns just after the CHK_L sampling edge.
    task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4);
        send_byte(b0); idle(4);
        send_byte(b1); idle(4);
        send_byte(b2); idle(4);
        send_byte(b3); idle(4);
        send_byte(b4);
    endtask

    initial begin
        logic [7:0] burst [10];
        burst = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h02, 8'h00, 8'h01, 8'h02, 8'h00, 8'h03};

        // Reset state
        idle(3);
        chk("rst_cmd", cmd, 0);
        chk("rst_flag", cmd_flag, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_type", err_type, 0);
        chk("rst_busy", busy, 0);
        sys_rst = 1'b1;
        idle(2);

        // Valid frame
        send_byte(8'h00);
        chk("busy_mid", busy, 1);
        idle(4);
        send_byte(8'h01); idle(4);
        send_byte(8'h01); idle(4);
        send_byte(8'h00); idle(4);
        send_byte(8'h02);
        chk("ok_flag", cmd_flag, 1);
        chk("ok_cmd", cmd, 8'h01);
        chk("ok_err", frame_err, 0);
        chk("ok_busy", busy, 0);
        idle(1);
        chk("ok_flag_1cyc", cmd_flag, 0);
        chk("ok_cmd_hold", cmd, 8'h01);

        // Checksum error
        send_frame(8'h00, 8'h01, 8'h01, 8'h00, 8'h03);
        chk("ck_err", frame_err, 1);
        chk("ck_type", err_type, 2'b01);
        chk("ck_flag", cmd_flag, 0);
        chk("ck_cmd", cmd, 8'h01);
        idle(1);
        chk("ck_err_1cyc", frame_err, 0);
        chk("ck_type_hold", err_type, 2'b01);

        // Foreign ID dropped, then broadcast accepted
        f0 = flag_cnt; e0 = err_cnt;
        send_frame(8'h00, 8'h02, 8'h07, 8'h00, 8'h09);
        idle(2);
        chk("foreign_flags", flag_cnt - f0, 0);
        chk("foreign_errs", err_cnt - e0, 0);
        chk("foreign_cmd", cmd, 8'h01);
        send_frame(8'hFF, 8'hFF, 8'h05, 8'h02, 8'h03);
        chk("bc_flag", cmd_flag, 1);
        chk("bc_cmd", cmd, 8'h05);
        idle(2);

        // Timeout: expires 20 edges after the ID_L strobe
        e0 = err_cnt;
        send_byte(8'h00); idle(4);
        send_byte(8'h01);
        hit = -1;
        for (int k = 1; k <= 25; k++) begin
            @(posedge sys_clk); #1;
            if (frame_err && hit < 0) hit = k;
        end
        chk("to_cycle", hit, 20);
        chk("to_count", err_cnt - e0, 1);
        chk("to_type", err_type, 2'b10);
        chk("to_busy", busy, 0);
        send_frame(8'h00, 8'h01, 8'h03, 8'h00, 8'h04);
        chk("to_rec_flag", cmd_flag, 1);
        chk("to_rec_cmd", cmd, 8'h03);
        idle(2);

        // Back-to-back: strobe every cycle for two frames
        f0 = flag_cnt;
        for (int i = 0; i < 10; i++) begin
            rx_data = burst[i];
            rx_flag = 1'b1;
            @(posedge sys_clk); #1;
            chk($sformatf("b2b_flag_%0d", i), cmd_flag, (i == 4 || i == 9) ? 1 : 0);
            if (i == 4) chk("b2b_cmd_a", cmd, 8'h01);
            if (i == 9) chk("b2b_cmd_b", cmd, 8'h02);
        end
        rx_flag = 1'b0;
        idle(2);
        chk("b2b_pulses", flag_cnt - f0, 2);

        // Reset mid-frame
        send_byte(8'h00); idle(4);
        send_byte(8'h01); idle(4);
        send_byte(8'h01);
        sys_rst = 1'b0;
        #1;
        for (int r = 0; r < 3; r++) begin
            chk("mr_cmd", cmd, 0);
            chk("mr_flag", cmd_flag, 0);
            chk("mr_err", frame_err, 0);
            chk("mr_type", err_type, 0);
            chk("mr_busy", busy, 0);
            @(posedge sys_clk); #1;
        end
        sys_rst = 1'b1;
        f0 = flag_cnt; e0 = err_cnt;
        idle(1);
        send_frame(8'h00, 8'h01, 8'h02, 8'h00, 8'h03);
        chk("mr_after_flag", cmd_flag, 1);
        chk("mr_after_cmd", cmd, 8'h02);
        idle(3);
        chk("mr_pulses", flag_cnt - f0, 1);
        chk("mr_errs", err_cnt - e0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
